// File: rtl/cbfp_pkg.sv
// -----------------------------------------------------------------------------
// cbfp_pkg
// Shared constants, sample/beat types and helpers for the CBFP stage-1
// exponent-detect path.
//   sample_t  : one signed butterfly output sample
//   beat_t    : one input beat, NUM_PATHS x BLOCK_SIZE samples, flattened as
//               index = path*BLOCK_SIZE + lane (path 0..3 = R_add, Q_add,
//               R_sub, Q_sub)
//   shift_t   : sign-bit count / block shift value
//   min_shift : smaller of two shift values
// -----------------------------------------------------------------------------
package cbfp_pkg;

    localparam int INPUT_WIDTH     = 25;
    localparam int SHIFT_WIDTH     = 5;
    localparam int BLOCK_SIZE      = 8;
    localparam int BEATS_PER_BLOCK = 8;
    localparam int NUM_PATHS       = 4;

    typedef logic signed [INPUT_WIDTH-1:0] sample_t;
    typedef sample_t [NUM_PATHS*BLOCK_SIZE-1:0] beat_t;
    typedef logic [SHIFT_WIDTH-1:0] shift_t;

    function automatic shift_t min_shift(input shift_t a, input shift_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cbfp_sign_count.sv
// -----------------------------------------------------------------------------
// cbfp_sign_count
// Combinational redundant-sign-bit counter: number of bits below the MSB that
// equal the MSB. 0 and -1 both give INPUT_WIDTH-1.
//   sample_i : signed sample
//   count_o  : redundant sign-bit count, 0..INPUT_WIDTH-1
// -----------------------------------------------------------------------------
module cbfp_sign_count
    import cbfp_pkg::*;
(
    input  sample_t sample_i,
    output shift_t  count_o
);

    always_comb begin
        logic run;
        count_o = '0;
        run     = 1'b1;
        // Scan downward from the bit under the MSB; the run ends at the first
        // bit that differs from the sign.
        for (int i = INPUT_WIDTH-2; i >= 0; i--) begin
            if (run && (sample_i[i] == sample_i[INPUT_WIDTH-1])) begin
                count_o = count_o + shift_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cbfp1_exp_detect.sv
// -----------------------------------------------------------------------------
// cbfp1_exp_detect
// Exponent detect and alignment buffer for the CBFP stage-1 normalizer. Finds
// the minimum redundant-sign-bit count per block for the add and sub paths and
// replays the buffered block together with its shift values.
//   clk, rstn                        : clock, async active-low reset
//   in_valid                         : input beat valid (no backpressure)
//   input_data_{R,Q}_{add,sub}       : input beat, BLOCK_SIZE lanes each
//   out_valid, out_first, out_last   : output beat framing
//   output_data_{R,Q}_{add,sub}      : delayed, unmodified beat
//   shift_value_add, shift_value_sub : block shifts, held for the whole block
// -----------------------------------------------------------------------------
module cbfp1_exp_detect #(
    parameter int INPUT_WIDTH     = cbfp_pkg::INPUT_WIDTH,
    parameter int BLOCK_SIZE      = cbfp_pkg::BLOCK_SIZE,
    parameter int BEATS_PER_BLOCK = cbfp_pkg::BEATS_PER_BLOCK,
    parameter int SHIFT_WIDTH     = cbfp_pkg::SHIFT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    input  logic signed [INPUT_WIDTH-1:0] input_data_R_add  [BLOCK_SIZE],
    input  logic signed [INPUT_WIDTH-1:0] input_data_Q_add  [BLOCK_SIZE],
    input  logic signed [INPUT_WIDTH-1:0] input_data_R_sub  [BLOCK_SIZE],
    input  logic signed [INPUT_WIDTH-1:0] input_data_Q_sub  [BLOCK_SIZE],
    output logic                          out_valid,
    output logic                          out_first,
    output logic                          out_last,
    output logic signed [INPUT_WIDTH-1:0] output_data_R_add [BLOCK_SIZE],
    output logic signed [INPUT_WIDTH-1:0] output_data_Q_add [BLOCK_SIZE],
    output logic signed [INPUT_WIDTH-1:0] output_data_R_sub [BLOCK_SIZE],
    output logic signed [INPUT_WIDTH-1:0] output_data_Q_sub [BLOCK_SIZE],
    output logic        [SHIFT_WIDTH-1:0] shift_value_add,
    output logic        [SHIFT_WIDTH-1:0] shift_value_sub
);

    import cbfp_pkg::*;

    localparam int CNT_W = $clog2(BEATS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BLOCK-1);
    localparam int NSAMP = NUM_PATHS*BLOCK_SIZE;

    beat_t  in_beat;
    shift_t cnt [NSAMP];
    shift_t beat_min_add;
    shift_t beat_min_sub;

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    shift_t           min_add_q, min_add_d;
    shift_t           min_sub_q, min_sub_d;
    shift_t           bank_shift_add_q [2];
    shift_t           bank_shift_sub_q [2];
    beat_t            mem_q [2][BEATS_PER_BLOCK];

    logic             rd_active_q, rd_active_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic             out_valid_q, out_first_q, out_last_q;
    beat_t            out_beat_q;
    shift_t           shift_add_q, shift_sub_q;

    logic             blk_done;
    logic             rd_last;

    always_comb begin
        in_beat = '0;
        for (int l = 0; l < BLOCK_SIZE; l++) begin
            in_beat[0*BLOCK_SIZE+l] = input_data_R_add[l];
            in_beat[1*BLOCK_SIZE+l] = input_data_Q_add[l];
            in_beat[2*BLOCK_SIZE+l] = input_data_R_sub[l];
            in_beat[3*BLOCK_SIZE+l] = input_data_Q_sub[l];
        end
    end

    for (genvar g = 0; g < NSAMP; g++) begin : g_sc
        cbfp_sign_count u_sc (
            .sample_i (in_beat[g]),
            .count_o  (cnt[g])
        );
    end

    // Per-path minimum over the current beat: add path uses samples 0..2*BS-1,
    // sub path uses 2*BS..4*BS-1.
    always_comb begin
        beat_min_add = cnt[0];
        beat_min_sub = cnt[2*BLOCK_SIZE];
        for (int i = 1; i < 2*BLOCK_SIZE; i++) begin
            beat_min_add = min_shift(beat_min_add, cnt[i]);
            beat_min_sub = min_shift(beat_min_sub, cnt[2*BLOCK_SIZE+i]);
        end
    end

    always_comb begin
        blk_done = in_valid && (beat_cnt_q == LAST_BEAT);
        rd_last  = rd_active_q && (rd_cnt_q == LAST_BEAT);

        beat_cnt_d = beat_cnt_q;
        min_add_d  = min_add_q;
        min_sub_d  = min_sub_q;
        if (in_valid) begin
            beat_cnt_d = blk_done ? '0 : beat_cnt_q + CNT_W'(1);
            // Beat 0 starts a fresh block: the old minimum is stale.
            if (beat_cnt_q == '0) begin
                min_add_d = beat_min_add;
                min_sub_d = beat_min_sub;
            end else begin
                min_add_d = min_shift(min_add_q, beat_min_add);
                min_sub_d = min_shift(min_sub_q, beat_min_sub);
            end
        end

        wr_bank_d = blk_done ? ~wr_bank_q : wr_bank_q;

        // A completing block (re)starts readout even while the previous
        // block's final beat is going out, keeping out_valid continuous.
        rd_active_d = rd_active_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        if (blk_done) begin
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
            rd_bank_d   = wr_bank_q;
        end else if (rd_active_q) begin
            rd_active_d = !rd_last;
            rd_cnt_d    = rd_last ? '0 : rd_cnt_q + CNT_W'(1);
        end
    end

    // ---- input side: counters, running minima, bank shifts ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt_q          <= '0;
            wr_bank_q           <= 1'b0;
            min_add_q           <= '0;
            min_sub_q           <= '0;
            bank_shift_add_q[0] <= '0;
            bank_shift_add_q[1] <= '0;
            bank_shift_sub_q[0] <= '0;
            bank_shift_sub_q[1] <= '0;
            rd_active_q         <= 1'b0;
            rd_bank_q           <= 1'b0;
            rd_cnt_q            <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            wr_bank_q   <= wr_bank_d;
            min_add_q   <= min_add_d;
            min_sub_q   <= min_sub_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            if (blk_done) begin
                bank_shift_add_q[wr_bank_q] <= min_add_d;
                bank_shift_sub_q[wr_bank_q] <= min_sub_d;
            end
        end
    end

    // Ping-pong block storage; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_q[wr_bank_q][beat_cnt_q] <= in_beat;
        end
    end

    // ---- output side: registered readout beat and shifts ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_beat_q  <= '0;
            shift_add_q <= '0;
            shift_sub_q <= '0;
        end else begin
            out_valid_q <= rd_active_q;
            out_first_q <= rd_active_q && (rd_cnt_q == '0);
            out_last_q  <= rd_last;
            if (rd_active_q) begin
                out_beat_q <= mem_q[rd_bank_q][rd_cnt_q];
            end
            if (rd_active_q && (rd_cnt_q == '0)) begin
                shift_add_q <= bank_shift_add_q[rd_bank_q];
                shift_sub_q <= bank_shift_sub_q[rd_bank_q];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < BLOCK_SIZE; l++) begin
            output_data_R_add[l] = out_beat_q[0*BLOCK_SIZE+l];
            output_data_Q_add[l] = out_beat_q[1*BLOCK_SIZE+l];
            output_data_R_sub[l] = out_beat_q[2*BLOCK_SIZE+l];
            output_data_Q_sub[l] = out_beat_q[3*BLOCK_SIZE+l];
        end
    end

    assign out_valid       = out_valid_q;
    assign out_first       = out_first_q;
    assign out_last        = out_last_q;
    assign shift_value_add = shift_add_q;
    assign shift_value_sub = shift_sub_q;

endmodule
